// File: rtl/system_unit.sv
// System unit: 64-bit cycle/time/instret counters, RD* counter reads, SCALL/SBREAK trap handshake.
// Reads answer one cycle after acceptance; o_busy holds upstream off while a trap waits for i_trap_ack.
package system_unit_pkg;
    typedef enum logic [3:0] {
        NOP,
        SCALL,
        SBREAK,
        RDCYCLE,
        RDCYCLEH,
        RDTIME,
        RDTIMEH,
        RDINSTRET,
        RDINSTRETH,
        FENCE,
        WFI
    } t_sysop;
endpackage

module system_unit
    import system_unit_pkg::*;
#(
    parameter int unsigned TIME_DIV   = 16,
    parameter int unsigned XLEN       = 32,
    // cycle counter reset value; 0 in normal use, nonzero only to start next to a carry boundary
    parameter logic [63:0] CYCLE_INIT = 64'd0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  t_sysop          i_sysop,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_retire,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_trap,
    output logic            o_trap_cause,
    output logic [XLEN-1:0] o_epc,
    input  logic            i_trap_ack
);
    localparam int unsigned   PW         = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIME_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESP,
        ST_TRAP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [63:0]   cycle_q;
    logic [63:0]   time_q;
    logic [63:0]   instret_q;
    logic [PW-1:0] presc_q;
    logic          time_tick;

    logic          rd_req;
    logic          rd_high;
    logic          trap_req;
    logic [63:0]   rd_src;
    logic [31:0]   rd_half;
    logic          accept_rd;
    logic          accept_trap;

    assign time_tick = (presc_q == PRESC_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle_q   <= CYCLE_INIT;
            time_q    <= '0;
            instret_q <= '0;
            presc_q   <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            presc_q <= time_tick ? '0 : presc_q + PW'(1);
            if (time_tick) begin
                time_q <= time_q + 64'd1;
            end
            if (i_retire) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    // Reads sample the registered counters, so a same-cycle increment is never visible
    always_comb begin
        rd_req   = 1'b0;
        rd_high  = 1'b0;
        trap_req = 1'b0;
        rd_src   = cycle_q;
        case (i_sysop)
            RDCYCLE: begin
                rd_req = 1'b1;
            end
            RDCYCLEH: begin
                rd_req  = 1'b1;
                rd_high = 1'b1;
            end
            RDTIME: begin
                rd_req = 1'b1;
                rd_src = time_q;
            end
            RDTIMEH: begin
                rd_req  = 1'b1;
                rd_high = 1'b1;
                rd_src  = time_q;
            end
            RDINSTRET: begin
                rd_req = 1'b1;
                rd_src = instret_q;
            end
            RDINSTRETH: begin
                rd_req  = 1'b1;
                rd_high = 1'b1;
                rd_src  = instret_q;
            end
            SCALL, SBREAK: begin
                trap_req = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rd_half = rd_high ? rd_src[63:32] : rd_src[31:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept_rd   = 1'b0;
        accept_trap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid && rd_req) begin
                    state_d   = ST_RESP;
                    accept_rd = 1'b1;
                end else if (i_valid && trap_req) begin
                    state_d     = ST_TRAP;
                    accept_trap = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_TRAP: begin
                if (i_trap_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result and trap info persist after their handshake until overwritten
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result     <= '0;
            o_trap_cause <= 1'b0;
            o_epc        <= '0;
        end else begin
            if (accept_rd) begin
                o_result <= XLEN'(rd_half);
            end
            if (accept_trap) begin
                o_trap_cause <= (i_sysop == SBREAK);
                o_epc        <= i_pc;
            end
        end
    end

    assign o_valid = (state_q == ST_RESP);
    assign o_busy  = (state_q == ST_TRAP);
    assign o_trap  = (state_q == ST_TRAP);

endmodule

// File: tb/tb_system_unit.sv
// Bench for system_unit: directed vector table, trap/reset sequences, then randomized run vs a reference model.
`timescale 1ns/1ps
module tb_system_unit;
    import system_unit_pkg::*;

    localparam int TDIV = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        valid    = 1'b0;
    t_sysop      sysop    = NOP;
    logic [31:0] pc       = '0;
    logic        retire   = 1'b0;
    logic        trap_ack = 1'b0;
    logic        busy, rvalid, trap, cause;
    logic [31:0] result, epc;

    logic        p_valid = 1'b0;
    t_sysop      p_sysop = NOP;
    logic        c_busy, c_valid, c_trap, c_cause;
    logic [31:0] c_result, c_epc;
    logic        w_busy, w_valid, w_trap, w_cause;
    logic [31:0] w_result, w_epc;

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;

    always #5 clk = ~clk;

    system_unit #(.TIME_DIV(TDIV), .XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_sysop(sysop), .i_pc(pc),
        .i_retire(retire), .o_busy(busy), .o_valid(rvalid), .o_result(result),
        .o_trap(trap), .o_trap_cause(cause), .o_epc(epc), .i_trap_ack(trap_ack)
    );

    system_unit #(.XLEN(32), .CYCLE_INIT(64'h0000_0000_FFFF_FFFF)) dut_carry (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(p_valid), .i_sysop(p_sysop), .i_pc(32'd0),
        .i_retire(1'b0), .o_busy(c_busy), .o_valid(c_valid), .o_result(c_result),
        .o_trap(c_trap), .o_trap_cause(c_cause), .o_epc(c_epc), .i_trap_ack(1'b0)
    );

    system_unit #(.XLEN(32), .CYCLE_INIT(64'hFFFF_FFFF_FFFF_FFFF)) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(p_valid), .i_sysop(p_sysop), .i_pc(32'd0),
        .i_retire(1'b0), .o_busy(w_busy), .o_valid(w_valid), .o_result(w_result),
        .o_trap(w_trap), .o_trap_cause(w_cause), .o_epc(w_epc), .i_trap_ack(1'b0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (n=%0d): got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    function automatic logic [31:0] model_read(input t_sysop op, input logic [63:0] cyc,
                                               input logic [63:0] ins);
        logic [63:0] v;
        case (op)
            RDCYCLE, RDCYCLEH: v = cyc;
            RDTIME, RDTIMEH:   v = cyc / TDIV;
            default:           v = ins;
        endcase
        if (op == RDCYCLEH || op == RDTIMEH || op == RDINSTRETH) return v[63:32];
        return v[31:0];
    endfunction

    typedef struct {
        int          idle;
        logic        ret_idle;
        t_sysop      op;
        logic        ret_op;
        logic        exp_vld;
        logic [31:0] exp_res;
    } vec_t;

    vec_t   vecs[11];
    t_sysop ops[11] = '{NOP, SCALL, SBREAK, RDCYCLE, RDCYCLEH, RDTIME, RDTIMEH,
                        RDINSTRET, RDINSTRETH, FENCE, WFI};

    initial begin
        logic [63:0] m_cyc, m_inst;
        logic [31:0] m_last, m_epc, rd_n;
        logic        m_vld, m_trap, m_cause, nvld;

        vecs[0]  = '{5, 1'b0, RDCYCLE,    1'b0, 1'b1, 32'd10};
        vecs[1]  = '{9, 1'b0, RDTIME,     1'b0, 1'b1, 32'd5};
        vecs[2]  = '{1, 1'b0, RDTIMEH,    1'b0, 1'b1, 32'd0};
        vecs[3]  = '{7, 1'b1, RDINSTRET,  1'b1, 1'b1, 32'd7};
        vecs[4]  = '{1, 1'b0, RDINSTRET,  1'b0, 1'b1, 32'd8};
        vecs[5]  = '{1, 1'b0, RDINSTRETH, 1'b0, 1'b1, 32'd0};
        vecs[6]  = '{1, 1'b0, RDCYCLEH,   1'b0, 1'b1, 32'd0};
        vecs[7]  = '{1, 1'b0, RDTIME,     1'b0, 1'b1, 32'd9};
        vecs[8]  = '{1, 1'b0, RDCYCLE,    1'b0, 1'b1, 32'd40};
        vecs[9]  = '{1, 1'b0, FENCE,      1'b0, 1'b0, 32'd40};
        vecs[10] = '{0, 1'b0, RDCYCLE,    1'b0, 1'b1, 32'd43};

        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", rvalid, 0);
        check("rst_result", result, 0);
        check("rst_trap", trap, 0);
        check("rst_cause", cause, 0);
        check("rst_epc", epc, 0);

        // preloaded counters: low-half carry and full 64-bit wrap
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        p_valid = 1'b1; p_sysop = RDCYCLE;
        tick();
        p_valid = 1'b0;
        check("carry_lo_vld", c_valid, 1);
        check("carry_lo", c_result, 32'hFFFF_FFFF);
        check("wrap_lo", w_result, 32'hFFFF_FFFF);
        tick();
        p_valid = 1'b1; p_sysop = RDCYCLEH;
        tick();
        p_valid = 1'b0;
        check("carry_hi", c_result, 32'd1);
        check("wrap_hi", w_result, 32'd0);
        tick();
        p_valid = 1'b1; p_sysop = RDCYCLE;
        tick();
        p_valid = 1'b0;
        check("carry_lo2", c_result, 32'd3);
        check("wrap_lo2", w_result, 32'd3);

        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < vecs[i].idle; j++) begin
                valid = 1'b0;
                retire = vecs[i].ret_idle;
                tick();
                check("idle_vld", rvalid, 0);
            end
            valid = 1'b1; sysop = vecs[i].op; retire = vecs[i].ret_op;
            tick();
            valid = 1'b0; retire = 1'b0;
            check($sformatf("vec%0d_vld", i), rvalid, vecs[i].exp_vld);
            check($sformatf("vec%0d_res", i), result, vecs[i].exp_res);
        end

        // ack outside TRAP is ignored; SBREAK trap with held read
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        check("stray_ack_trap", trap, 0);
        check("stray_ack_busy", busy, 0);
        valid = 1'b1; sysop = SBREAK; pc = 32'h0000_0100;
        tick();
        check("sbreak_trap", trap, 1);
        check("sbreak_cause", cause, 1);
        check("sbreak_epc", epc, 32'h100);
        check("sbreak_busy", busy, 1);
        sysop = RDCYCLE; pc = 32'h0000_0104;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("held_trap", trap, 1);
            check("held_busy", busy, 1);
            check("held_vld", rvalid, 0);
            check("held_epc", epc, 32'h100);
        end
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        check("ack_trap", trap, 0);
        check("ack_busy", busy, 0);
        rd_n = n;
        tick();
        valid = 1'b0;
        check("post_trap_vld", rvalid, 1);
        check("post_trap_res", result, rd_n);

        // reset in the middle of an SCALL trap
        tick();
        valid = 1'b1; sysop = SCALL; pc = 32'h0000_2468;
        tick();
        valid = 1'b0;
        check("scall_trap", trap, 1);
        check("scall_cause", cause, 0);
        check("scall_epc", epc, 32'h2468);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_trap", trap, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_epc", epc, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_valid", rvalid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("after_rst_vld", rvalid, 0);
            check("after_rst_trap", trap, 0);
        end
        valid = 1'b1; sysop = RDCYCLE;
        tick();
        valid = 1'b0;
        check("rst_cycle_vld", rvalid, 1);
        check("rst_cycle", result, 32'd3);
        tick();
        valid = 1'b1; sysop = RDINSTRET;
        tick();
        valid = 1'b0;
        check("rst_instret", result, 32'd0);
        tick();

        // randomized run against the reference model
        m_cyc = 64'(n); m_inst = '0; m_last = '0;
        m_vld = 1'b0; m_trap = 1'b0; m_cause = 1'b0; m_epc = '0;
        for (int it = 0; it < 600; it++) begin
            valid    = ($urandom_range(0, 2) != 0);
            sysop    = ops[$urandom_range(0, 10)];
            retire   = $urandom_range(0, 1) == 1;
            trap_ack = ($urandom_range(0, 3) == 0);
            pc       = $urandom;
            nvld = 1'b0;
            if (m_trap) begin
                m_trap = !trap_ack;
            end else if (!m_vld && valid) begin
                if (sysop inside {RDCYCLE, RDCYCLEH, RDTIME, RDTIMEH, RDINSTRET, RDINSTRETH}) begin
                    nvld   = 1'b1;
                    m_last = model_read(sysop, m_cyc, m_inst);
                end else if (sysop == SCALL || sysop == SBREAK) begin
                    m_trap  = 1'b1;
                    m_cause = (sysop == SBREAK);
                    m_epc   = pc;
                end
            end
            m_vld = nvld;
            m_cyc = m_cyc + 64'd1;
            if (retire) m_inst = m_inst + 64'd1;
            tick();
            check("rnd_vld", rvalid, m_vld);
            check("rnd_busy", busy, m_trap);
            check("rnd_trap", trap, m_trap);
            check("rnd_result", result, m_last);
            if (m_trap) begin
                check("rnd_cause", cause, m_cause);
                check("rnd_epc", epc, m_epc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
